// File: rtl/qddc_iq_fifo.sv
// qddc_iq_fifo
// Packs each decimated I/Q sample pair from the quadrature DDC into a
// {q, i} word and buffers it in a first-word-fall-through FIFO. The FIFO
// is a (DEPTH-1)-entry RAM plus one output register, for DEPTH words in total.
// Words are presented to the host stream over a valid/ready handshake.
// A write that arrives while the FIFO is full is dropped and sets the
// sticky overflow flag.
//
// Optional feature: define QDDC_IQ_FIFO_DROP_CNT_EN to add a 16-bit
// saturating drop counter (drop_cnt) that is cleared by overflow_clr.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   in_valid, in_i, in_q decimated sample strobe and signed I/Q components
//   enable               capture enable (strobes ignored when low)
//   flush                synchronous discard of all stored words
//   out_data/valid/ready packed word stream toward the host
//   level                words held, 0..DEPTH, including the output register
//   overflow             sticky "sample dropped" flag
//   overflow_clr         clears overflow (and drop_cnt when present)
//   drop_cnt             dropped-write count (QDDC_IQ_FIFO_DROP_CNT_EN only)
module qddc_iq_fifo #(
    parameter int ISZ   = 16,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [ISZ-1:0]   in_i,
    input  logic [ISZ-1:0]   in_q,
    input  logic             enable,
    input  logic             flush,
    output logic [2*ISZ-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      level,
    output logic             overflow,
`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
    output logic [15:0]      drop_cnt,
`endif
    input  logic             overflow_clr
);

    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [2*ISZ-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    ram_cnt;

    logic [2*ISZ-1:0] in_word;
    logic             full;
    logic             ram_empty;
    logic             strobe;
    logic             wr;
    logic             drop;
    logic             rd;
    logic             out_free;
    logic             refill;
    logic             direct;
    logic             ram_push;

    assign in_word   = {in_q, in_i};
    // Full is judged on the pre-edge level, so a same-cycle read cannot
    // make room for a write that arrives while full.
    assign full      = (level == LVL_FULL);
    assign ram_empty = (ram_cnt == '0);
    assign strobe    = in_valid & enable & ~flush;
    assign wr        = strobe & ~full;
    assign drop      = strobe & full;
    assign rd        = out_valid & out_ready;
    // Output register can take a new word this edge.
    assign out_free  = ~out_valid | rd;
    // The RAM head always goes first to keep ordering; a new word only
    // bypasses the RAM into the output register when the RAM is empty.
    assign refill    = out_free & ~ram_empty;
    assign direct    = wr & out_free & ram_empty;
    assign ram_push  = wr & ~direct;

    // RAM storage is not reset; contents are qualified by ram_cnt.
    always_ff @(posedge clk) begin
        if (ram_push) begin
            mem[wr_ptr] <= in_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            level     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            // out_data deliberately keeps its stale value.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            level     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (refill) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + 1'b1;
            end else if (direct) begin
                out_data  <= in_word;
                out_valid <= 1'b1;
            end else if (rd) begin
                out_valid <= 1'b0;
            end
            if (ram_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            ram_cnt <= ram_cnt + AW'(ram_push) - AW'(refill);
            level   <= level + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    // Set wins over clear so a drop coinciding with a clear is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (overflow_clr) begin
                drop_cnt <= 16'd1;
            end else if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (overflow_clr) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_qddc_iq_fifo.sv
module tb_qddc_iq_fifo;
    localparam int ISZ   = 16;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_i = '0;
    logic [15:0] in_q = '0;
    logic        enable = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [6:0]  level;
    logic        overflow;
`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    qddc_iq_fifo #(.ISZ(ISZ), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_i         (in_i),
        .in_q         (in_q),
        .enable       (enable),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard and reference state
    logic [31:0] sb[$];
    int          exp_level = 0;
    bit          exp_ovf = 1'b0;
    int          exp_drop = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          seq = 0;

    // On each falling edge: compare outputs to the reference, then predict
    // the effect of the inputs that will be sampled on the next rising edge.
    always @(negedge clk) begin
        bit st, w, d, r;
        if (!reset) begin
            n_checks++;
            if (level !== 7'(exp_level)) begin
                n_fail++; $display("FAIL mon_level: got %0d want %0d", level, exp_level);
            end
            n_checks++;
            if (out_valid !== (exp_level != 0)) begin
                n_fail++; $display("FAIL mon_valid: got %0b want %0b", out_valid, exp_level != 0);
            end
            n_checks++;
            if (overflow !== exp_ovf) begin
                n_fail++; $display("FAIL mon_overflow: got %0b want %0b", overflow, exp_ovf);
            end
            if (exp_level > 0 && sb.size() > 0) begin
                n_checks++;
                if (out_data !== sb[0]) begin
                    n_fail++; $display("FAIL mon_data: got %h want %h", out_data, sb[0]);
                end
            end
`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
            n_checks++;
            if (drop_cnt !== 16'(exp_drop)) begin
                n_fail++; $display("FAIL mon_drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
            end
`endif
            st = in_valid && enable && !flush;
            w  = st && (exp_level < DEPTH);
            d  = st && (exp_level == DEPTH);
            r  = out_ready && (exp_level > 0);
            if (flush) begin
                sb.delete();
                exp_level = 0;
            end else begin
                if (r) void'(sb.pop_front());
                if (w) sb.push_back({in_q, in_i});
                exp_level = exp_level + int'(w) - int'(r);
            end
            if (d) exp_ovf = 1'b1;
            else if (overflow_clr) exp_ovf = 1'b0;
            if (d) exp_drop = overflow_clr ? 1 : ((exp_drop == 65535) ? 65535 : exp_drop + 1);
            else if (overflow_clr) exp_drop = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb.delete();
        exp_level = 0;
        exp_ovf   = 1'b0;
        exp_drop  = 0;
    endtask

    task automatic strobe(input logic [15:0] i, input logic [15:0] q);
        in_valid = 1'b1; in_i = i; in_q = q;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) begin
            strobe(16'(seq), 16'(-seq));
            seq++;
        end
    endtask

    task automatic clear_ovf();
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || level !== 7'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b d=%h l=%0d o=%0b want 0 0 0 0", out_valid, out_data, level, overflow);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        enable = 1'b1; out_ready = 1'b1;
        strobe(16'h1234, 16'hABCD);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hABCD1234) begin
            n_fail++; $display("FAIL single_word: got v=%0b d=%h want 1 abcd1234", out_valid, out_data);
        end
        tick();
        n_checks++;
        if (level !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_drain: got l=%0d v=%0b want 0 0", level, out_valid);
        end
    endtask

    task automatic test_fill_overflow();
        out_ready = 1'b0;
        seq = 0;
        fill(64);
        n_checks++;
        if (level !== 7'd64 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL fill_full: got l=%0d o=%0b want 64 0", level, overflow);
        end
        strobe(16'h0FFF, 16'hF001);
        n_checks++;
        if (level !== 7'd64 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL fill_drop: got l=%0d o=%0b want 64 1", level, overflow);
        end
`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL fill_drop_cnt: got %0d want 1", drop_cnt);
        end
`endif
        n_checks++;
        if (out_data !== 32'h0000_0000) begin
            n_fail++; $display("FAIL fill_head: got %h want 00000000", out_data);
        end
        out_ready = 1'b1;
        repeat (64) tick();
        out_ready = 1'b0;
        n_checks++;
        if (level !== 7'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL fill_drained: got l=%0d v=%0b want 0 0", level, out_valid);
        end
        clear_ovf();
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %0b want 0", overflow);
        end
    endtask

    task automatic test_full_rw();
        out_ready = 1'b0;
        fill(64);
        in_valid = 1'b1; in_i = 16'h5555; in_q = 16'hAAAA; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++;
        if (level !== 7'd63 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL full_rw: got l=%0d o=%0b want 63 1", level, overflow);
        end
        out_ready = 1'b1;
        repeat (63) tick();
        out_ready = 1'b0;
        clear_ovf();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        fill(10);
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1; in_i = 16'(seq); in_q = 16'(-seq); seq++;
            tick();
            n_checks++;
            if (level !== 7'd10) begin
                n_fail++; $display("FAIL b2b_level: cycle %0d got %0d want 10", c, level);
            end
        end
        in_valid = 1'b0;
        repeat (10) tick();
        out_ready = 1'b0;
        n_checks++;
        if (level !== 7'd0) begin
            n_fail++; $display("FAIL b2b_drained: got %0d want 0", level);
        end
    endtask

    task automatic test_flush_reset();
        logic saved;
        out_ready = 1'b0;
        fill(20);
        saved = overflow;
        flush = 1'b1; in_valid = 1'b1; in_i = 16'h7777; in_q = 16'h8888;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (level !== 7'd0 || out_valid !== 1'b0 || overflow !== saved) begin
            n_fail++; $display("FAIL flush: got l=%0d v=%0b o=%0b want 0 0 %0b", level, out_valid, overflow, saved);
        end
        // Async reset arriving mid-burst, between clock edges
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_i = 16'(seq); in_q = 16'(-seq); seq++;
            tick();
        end
        overflow_clr = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || level !== 7'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%0b d=%h l=%0d o=%0b want 0 0 0 0", out_valid, out_data, level, overflow);
        end
        in_valid = 1'b0;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_enable();
        enable = 1'b0; out_ready = 1'b0;
        fill(5);
        n_checks++;
        if (level !== 7'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL enable_off: got l=%0d o=%0b want 0 0", level, overflow);
        end
        enable = 1'b1;
        fill(64);
        in_valid = 1'b1; overflow_clr = 1'b1;
        tick();
        in_valid = 1'b0; overflow_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b1 || level !== 7'd64) begin
            n_fail++; $display("FAIL set_beats_clr: got o=%0b l=%0d want 1 64", overflow, level);
        end
`ifdef QDDC_IQ_FIFO_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 16'd1) begin
            n_fail++; $display("FAIL drop_cnt_clr_inc: got %0d want 1", drop_cnt);
        end
`endif
        out_ready = 1'b1;
        repeat (64) tick();
        out_ready = 1'b0;
        clear_ovf();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_rw();
        test_back_to_back();
        test_flush_reset();
        test_enable();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
